// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, LSB-first payload, optional even/odd parity,
// one or two stop bits. Frames can run back-to-back with no idle gap.
module uart_tx_frame #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic                  stop2,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int PW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [PW-1:0]         r_prescale;
  logic [BW-1:0]         r_bitCnt;
  logic                  r_stopCnt;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_parEn;
  logic                  r_parTyp;
  logic                  r_stop2;

  logic w_bitTick;
  logic w_lastBit;
  logic w_lastStop;
  logic w_accept;

  assign w_bitTick  = (r_prescale == PRE_LAST);
  assign w_lastBit  = (r_bitCnt == BIT_LAST);
  assign w_lastStop = (r_state == STOP) && w_bitTick && (r_stopCnt == r_stop2);
  assign w_accept   = data_valid && ((r_state == IDLE) || w_lastStop);

  // State register; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic; unknown encodings fall back to IDLE.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (data_valid) w_nextState = START;
      START:   if (w_bitTick) w_nextState = DATA;
      DATA:    if (w_bitTick && w_lastBit) w_nextState = r_parEn ? PARITY : STOP;
      PARITY:  if (w_bitTick) w_nextState = STOP;
      STOP:    if (w_lastStop) w_nextState = data_valid ? START : IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Prescale, bit and stop counters plus the per-frame holding registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prescale <= '0;
      r_bitCnt   <= '0;
      r_stopCnt  <= 1'b0;
      r_data     <= '0;
      r_parEn    <= 1'b0;
      r_parTyp   <= 1'b0;
      r_stop2    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_data   <= p_data;
        r_parEn  <= par_en;
        r_parTyp <= par_typ;
        r_stop2  <= stop2;
      end
      if ((r_state == IDLE) || w_bitTick) begin
        r_prescale <= '0;
      end else begin
        r_prescale <= r_prescale + PW'(1);
      end
      if ((r_state == DATA) && w_bitTick) begin
        r_bitCnt <= w_lastBit ? '0 : r_bitCnt + BW'(1);
      end
      if ((r_state == STOP) && w_bitTick) begin
        r_stopCnt <= w_lastStop ? 1'b0 : 1'b1;
      end
    end
  end

  // Output decode from registered state and counters only.
  always_comb begin
    tx_out  = 1'b1;
    busy    = 1'b1;
    tx_done = w_lastStop;
    case (r_state)
      IDLE:    busy = 1'b0;
      START:   tx_out = 1'b0;
      DATA:    tx_out = r_data[r_bitCnt];
      PARITY:  tx_out = (^r_data) ^ r_parTyp;
      STOP:    tx_out = 1'b1;
      default: begin
        tx_out = 1'b1;
        busy   = 1'b0;
      end
    endcase
  end

endmodule
